// File: rtl/axis_mem_wr_arbiter_if.sv
// AXI-Stream link bundle used for both arbiter requesters and the memory-side master.
interface axis_mem_wr_arbiter_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0]   tdata;
    logic [DATA_WIDTH/8-1:0] tstrb;
    logic                    tvalid;
    logic                    tlast;
    logic                    tready;

    modport master (output tdata, tstrb, tvalid, tlast, input  tready);
    modport slave  (input  tdata, tstrb, tvalid, tlast, output tready);
endinterface

// File: rtl/axis_mem_wr_arbiter.sv
// Two-requester, packet-granular round-robin arbiter for the memory write stream.
// A granted requester owns m00 until its tlast beat (or a forced tlast at
// MAX_BEATS) transfers; then ownership returns to IDLE for one arbitration cycle.
module axis_mem_wr_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BEATS  = 256,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  axis_aclk,
    input  logic                  axis_aresetn,
    axis_mem_wr_arbiter_if.slave  s00_axis,
    axis_mem_wr_arbiter_if.slave  s01_axis,
    axis_mem_wr_arbiter_if.master m00_axis,
    output logic [1:0]            grant,
    output logic [CNT_WIDTH-1:0]  pkt_cnt0,
    output logic [CNT_WIDTH-1:0]  pkt_cnt1,
    output logic                  overlen_err
);
    localparam int            BW       = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
    localparam logic [BW-1:0] LAST_IDX = BW'(MAX_BEATS - 1);
    localparam int            SW       = DATA_WIDTH / 8;

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_rr_ptr;
    logic [BW-1:0]         r_beat_cnt;
    logic [CNT_WIDTH-1:0]  r_pkt_cnt0;
    logic [CNT_WIDTH-1:0]  r_pkt_cnt1;
    logic                  r_overlen;

    logic [DATA_WIDTH-1:0] w_sel_tdata;
    logic [SW-1:0]         w_sel_tstrb;
    logic                  w_sel_tvalid;
    logic                  w_src_tlast;
    logic                  w_last;
    logic                  w_xfer;
    logic                  w_last_xfer;

    // State register; reset drops ownership immediately, so a partial packet never completes.
    always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
        if (!axis_aresetn) r_state <= IDLE;
        else               r_state <= w_state_nxt;
    end

    // Arbitration, owner mux and next-state; IDLE never passes a beat.
    always_comb begin
        w_state_nxt     = r_state;
        w_sel_tdata     = '0;
        w_sel_tstrb     = '0;
        w_sel_tvalid    = 1'b0;
        w_src_tlast     = 1'b0;
        grant           = 2'b00;
        s00_axis.tready = 1'b0;
        s01_axis.tready = 1'b0;
        unique case (r_state)
            IDLE: begin
                // rr_ptr only breaks ties; a lone requester always wins
                if (s00_axis.tvalid && (!s01_axis.tvalid || !r_rr_ptr)) w_state_nxt = OWN0;
                else if (s01_axis.tvalid)                               w_state_nxt = OWN1;
            end
            OWN0: begin
                grant           = 2'b01;
                w_sel_tdata     = s00_axis.tdata;
                w_sel_tstrb     = s00_axis.tstrb;
                w_sel_tvalid    = s00_axis.tvalid;
                w_src_tlast     = s00_axis.tlast;
                s00_axis.tready = m00_axis.tready;
            end
            OWN1: begin
                grant           = 2'b10;
                w_sel_tdata     = s01_axis.tdata;
                w_sel_tstrb     = s01_axis.tstrb;
                w_sel_tvalid    = s01_axis.tvalid;
                w_src_tlast     = s01_axis.tlast;
                s01_axis.tready = m00_axis.tready;
            end
            default: w_state_nxt = IDLE;
        endcase
        w_last      = w_src_tlast || (r_beat_cnt == LAST_IDX);
        w_xfer      = w_sel_tvalid && m00_axis.tready;
        w_last_xfer = w_xfer && w_last;
        if (w_last_xfer) w_state_nxt = IDLE;
    end

    assign m00_axis.tdata  = w_sel_tdata;
    assign m00_axis.tstrb  = w_sel_tstrb;
    assign m00_axis.tvalid = w_sel_tvalid;
    assign m00_axis.tlast  = w_sel_tvalid && w_last;

    // Beat counter, round-robin pointer, packet counters and forced-tlast pulse.
    always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
        if (!axis_aresetn) begin
            r_rr_ptr   <= 1'b0;
            r_beat_cnt <= '0;
            r_pkt_cnt0 <= '0;
            r_pkt_cnt1 <= '0;
            r_overlen  <= 1'b0;
        end else begin
            r_overlen <= w_last_xfer && !w_src_tlast;
            if (w_last_xfer) begin
                r_beat_cnt <= '0;
                // prefer the requester that did not just finish
                r_rr_ptr   <= (r_state == OWN0);
                if (r_state == OWN0) r_pkt_cnt0 <= r_pkt_cnt0 + 1'b1;
                else                 r_pkt_cnt1 <= r_pkt_cnt1 + 1'b1;
            end else if (w_xfer) begin
                r_beat_cnt <= r_beat_cnt + 1'b1;
            end
        end
    end

    assign pkt_cnt0    = r_pkt_cnt0;
    assign pkt_cnt1    = r_pkt_cnt1;
    assign overlen_err = r_overlen;
endmodule

// File: tb/tb_axis_mem_wr_arbiter.sv
// Directed bench for axis_mem_wr_arbiter: MAX_BEATS=4 for forced-tlast, CNT_WIDTH=3 for wrap.
module tb_axis_mem_wr_arbiter;
    localparam int DW = 32;
    localparam int MB = 4;
    localparam int CW = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    axis_mem_wr_arbiter_if #(.DATA_WIDTH(DW)) s00_if ();
    axis_mem_wr_arbiter_if #(.DATA_WIDTH(DW)) s01_if ();
    axis_mem_wr_arbiter_if #(.DATA_WIDTH(DW)) m00_if ();

    logic [1:0]    grant;
    logic [CW-1:0] pkt_cnt0;
    logic [CW-1:0] pkt_cnt1;
    logic          overlen_err;

    axis_mem_wr_arbiter #(.DATA_WIDTH(DW), .MAX_BEATS(MB), .CNT_WIDTH(CW)) dut (
        .axis_aclk    (clk),
        .axis_aresetn (rst_n),
        .s00_axis     (s00_if),
        .s01_axis     (s01_if),
        .m00_axis     (m00_if),
        .grant        (grant),
        .pkt_cnt0     (pkt_cnt0),
        .pkt_cnt1     (pkt_cnt1),
        .overlen_err  (overlen_err)
    );

    int n_checks = 0;
    int n_errors = 0;
    // per-source stream position: packet, beat, packets to send, beats per packet
    int pk[2];
    int bt[2];
    int npk[2];
    int plen[2];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] mkd(input int s, input int p, input int b);
        return 32'(s * 65536 + p * 256 + b);
    endfunction

    function automatic logic [3:0] mks(input int b);
        return 4'(b + 1);
    endfunction

    task automatic drive_srcs();
        s00_if.tvalid = (pk[0] < npk[0]);
        s00_if.tdata  = mkd(0, pk[0], bt[0]);
        s00_if.tstrb  = mks(bt[0]);
        s00_if.tlast  = (bt[0] == plen[0] - 1);
        s01_if.tvalid = (pk[1] < npk[1]);
        s01_if.tdata  = mkd(1, pk[1], bt[1]);
        s01_if.tstrb  = mks(bt[1]);
        s01_if.tlast  = (bt[1] == plen[1] - 1);
    endtask

    task automatic clear_streams();
        for (int s = 0; s < 2; s++) begin
            pk[s] = 0; bt[s] = 0; npk[s] = 0; plen[s] = 1;
        end
    endtask

    // advance a source whose beat is accepted at the coming edge
    task automatic retire();
        logic f0, f1;
        f0 = s00_if.tvalid && s00_if.tready;
        f1 = s01_if.tvalid && s01_if.tready;
        if (f0) begin
            if (bt[0] == plen[0] - 1) begin bt[0] = 0; pk[0]++; end
            else bt[0]++;
        end
        if (f1) begin
            if (bt[1] == plen[1] - 1) begin bt[1] = 0; pk[1]++; end
            else bt[1]++;
        end
    endtask

    // called just after a sample point (before the rising edge); moves to next cycle's sample point
    task automatic tick(input logic mrdy);
        retire();
        @(negedge clk);
        m00_if.tready = mrdy;
        drive_srcs();
        #1;
    endtask

    task automatic exp_m(input string tag, input logic [1:0] g, input logic v,
                         input logic [31:0] d, input logic [3:0] s, input logic l);
        chk({tag, "_grant"}, 32'(grant), 32'(g));
        chk({tag, "_tvalid"}, 32'(m00_if.tvalid), 32'(v));
        chk({tag, "_tlast"}, 32'(m00_if.tlast), 32'(l));
        if (v) begin
            chk({tag, "_tdata"}, m00_if.tdata, d);
            chk({tag, "_tstrb"}, 32'(m00_if.tstrb), 32'(s));
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        clear_streams();
        drive_srcs();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        clear_streams();
        m00_if.tready = 1'b1;
        drive_srcs();

        // 1. reset held with both requesters valid
        npk[0] = 1; npk[1] = 1;
        @(negedge clk);
        drive_srcs();
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_s00_rdy", 32'(s00_if.tready), 32'd0);
        chk("rst_s01_rdy", 32'(s01_if.tready), 32'd0);
        chk("rst_m_tvalid", 32'(m00_if.tvalid), 32'd0);
        chk("rst_m_tlast", 32'(m00_if.tlast), 32'd0);
        chk("rst_cnt0", 32'(pkt_cnt0), 32'd0);
        chk("rst_cnt1", 32'(pkt_cnt1), 32'd0);
        chk("rst_ovl", 32'(overlen_err), 32'd0);
        @(negedge clk);
        clear_streams();
        drive_srcs();
        rst_n = 1'b1;
        #1;
        chk("post_rst_grant", 32'(grant), 32'd0);

        // 2. s00 alone, 4-beat packet
        npk[0] = 1; plen[0] = 4;
        tick(1'b1);
        exp_m("t2_idle", 2'b00, 1'b0, '0, '0, 1'b0);
        chk("t2_idle_rdy", 32'(s00_if.tready), 32'd0);
        for (int b = 0; b < 4; b++) begin
            tick(1'b1);
            exp_m("t2_beat", 2'b01, 1'b1, mkd(0, 0, b), mks(b), b == 3);
            chk("t2_rdy", 32'(s00_if.tready), 32'd1);
        end
        tick(1'b1);
        chk("t2_grant_end", 32'(grant), 32'd0);
        chk("t2_cnt0", 32'(pkt_cnt0), 32'd1);
        chk("t2_ovl", 32'(overlen_err), 32'd0);

        // 3. both valid, 3-beat packets, 2 each: strict alternation starting at s00
        do_reset();
        npk[0] = 2; npk[1] = 2; plen[0] = 3; plen[1] = 3;
        for (int k = 0; k < 4; k++) begin
            tick(1'b1);
            exp_m("t3_idle", 2'b00, 1'b0, '0, '0, 1'b0);
            for (int b = 0; b < 3; b++) begin
                tick(1'b1);
                exp_m("t3_beat", (k % 2 == 0) ? 2'b01 : 2'b10, 1'b1,
                      mkd(k % 2, k / 2, b), mks(b), b == 2);
                chk("t3_other_rdy", 32'((k % 2 == 0) ? s01_if.tready : s00_if.tready), 32'd0);
            end
        end
        tick(1'b1);
        chk("t3_cnt0", 32'(pkt_cnt0), 32'd2);
        chk("t3_cnt1", 32'(pkt_cnt1), 32'd2);

        // 4. s01 6-beat packet with MAX_BEATS=4: forced tlast on beat 4
        clear_streams();
        npk[1] = 1; plen[1] = 6;
        tick(1'b1);
        exp_m("t4_idle", 2'b00, 1'b0, '0, '0, 1'b0);
        for (int b = 0; b < 4; b++) begin
            tick(1'b1);
            exp_m("t4_beat", 2'b10, 1'b1, mkd(1, 0, b), mks(b), b == 3);
            chk("t4_ovl_lo", 32'(overlen_err), 32'd0);
        end
        tick(1'b1);
        exp_m("t4_rearb", 2'b00, 1'b0, '0, '0, 1'b0);
        chk("t4_ovl_pulse", 32'(overlen_err), 32'd1);
        for (int b = 4; b < 6; b++) begin
            tick(1'b1);
            exp_m("t4_tail", 2'b10, 1'b1, mkd(1, 0, b), mks(b), b == 5);
            chk("t4_ovl_once", 32'(overlen_err), 32'd0);
        end
        tick(1'b1);
        chk("t4_ovl_end", 32'(overlen_err), 32'd0);
        chk("t4_cnt1", 32'(pkt_cnt1), 32'd4);

        // counter wrap: four 1-beat packets take pkt_cnt1 4 -> 0
        clear_streams();
        npk[1] = 4; plen[1] = 1;
        for (int k = 0; k < 4; k++) begin
            tick(1'b1);
            chk("wrap_cnt1", 32'(pkt_cnt1), 32'(4 + k));
            tick(1'b1);
            exp_m("wrap_beat", 2'b10, 1'b1, mkd(1, k, 0), mks(0), 1'b1);
        end
        tick(1'b1);
        chk("wrap_cnt1_zero", 32'(pkt_cnt1), 32'd0);
        chk("wrap_cnt0", 32'(pkt_cnt0), 32'd2);

        // 5. stalls mid-packet: ready 1,0,0,1 then 1,1
        begin
            logic rdy [6];
            int   eb  [6];
            rdy = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
            eb  = '{0, 1, 1, 1, 2, 3};
            clear_streams();
            npk[0] = 1; plen[0] = 4;
            tick(1'b1);
            exp_m("t5_idle", 2'b00, 1'b0, '0, '0, 1'b0);
            for (int c = 0; c < 6; c++) begin
                tick(rdy[c]);
                exp_m("t5_beat", 2'b01, 1'b1, mkd(0, 0, eb[c]), mks(eb[c]), eb[c] == 3);
                chk("t5_rdy_mirror", 32'(s00_if.tready), 32'(rdy[c]));
            end
            tick(1'b1);
            chk("t5_grant_end", 32'(grant), 32'd0);
            chk("t5_cnt0", 32'(pkt_cnt0), 32'd3);
        end

        // 6. reset asserted after beat 2 of a 5-beat packet
        clear_streams();
        npk[0] = 1; plen[0] = 5;
        tick(1'b1);
        exp_m("t6_idle", 2'b00, 1'b0, '0, '0, 1'b0);
        for (int b = 0; b < 2; b++) begin
            tick(1'b1);
            exp_m("t6_beat", 2'b01, 1'b1, mkd(0, 0, b), mks(b), 1'b0);
        end
        tick(1'b1);
        exp_m("t6_beat3", 2'b01, 1'b1, mkd(0, 0, 2), mks(2), 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_async_grant", 32'(grant), 32'd0);
        chk("t6_async_rdy", 32'(s00_if.tready), 32'd0);
        chk("t6_async_tvalid", 32'(m00_if.tvalid), 32'd0);
        chk("t6_async_tlast", 32'(m00_if.tlast), 32'd0);
        chk("t6_cnt0", 32'(pkt_cnt0), 32'd0);
        @(negedge clk);
        clear_streams();
        drive_srcs();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        npk[0] = 1; plen[0] = 2;
        tick(1'b1);
        exp_m("t6_new_idle", 2'b00, 1'b0, '0, '0, 1'b0);
        for (int b = 0; b < 2; b++) begin
            tick(1'b1);
            exp_m("t6_new_beat", 2'b01, 1'b1, mkd(0, 0, b), mks(b), b == 1);
        end
        tick(1'b1);
        chk("t6_new_cnt0", 32'(pkt_cnt0), 32'd1);
        chk("t6_new_ovl", 32'(overlen_err), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
